// File: rtl/pipelined_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request and
// decode-side queue head. The fetch stage owns the master modport.
interface pipelined_fetch_stage_if #(
   parameter int XLEN     = 32,
   parameter int IQ_DEPTH = 4
);
   localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

   logic [XLEN-1:0]  imem_addr;
   logic [31:0]      imem_rdata;
   logic             redirect_valid;
   logic [1:0]       redirect_kind;
   logic [XLEN-1:0]  redirect_base;
   logic [25:0]      redirect_index;
   logic [XLEN-1:0]  redirect_reg;
   logic [15:0]      redirect_imm;
   logic             id_valid;
   logic             id_ready;
   logic [31:0]      id_instr;
   logic [XLEN-1:0]  id_pc;
   logic [CNT_W-1:0] iq_count;
   logic             misalign_pulse;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid, redirect_kind, redirect_base,
      input  redirect_index, redirect_reg, redirect_imm,
      output id_valid,
      input  id_ready,
      output id_instr, id_pc, iq_count, misalign_pulse
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid, redirect_kind, redirect_base,
      output redirect_index, redirect_reg, redirect_imm,
      input  id_valid,
      output id_ready,
      input  id_instr, id_pc, iq_count, misalign_pulse
   );
endinterface

// File: rtl/pipelined_fetch_stage.sv
// Fetch stage: PC register, redirect target unit and circular instruction queue.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt/flush_cnt outputs.
module pipelined_fetch_stage #(
   parameter int              XLEN     = 32,
   parameter int              IQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0080
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipelined_fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            fetch_cnt,
   output logic [15:0]            flush_cnt
`endif
);

   localparam int              PTR_W    = $clog2(IQ_DEPTH);
   localparam int              CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

   logic [XLEN-1:0]  pc;
   logic [31:0]      instr_q [IQ_DEPTH];
   logic [XLEN-1:0]  pc_q    [IQ_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             misalign;
   logic             head_valid;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  base_plus4;
   logic [XLEN-1:0]  branch_off;
   logic [XLEN-1:0]  target;

   always_comb begin
      base_plus4 = bus.redirect_base + XLEN'(4);
      branch_off = {{(XLEN-18){bus.redirect_imm[15]}}, bus.redirect_imm, 2'b00};
      target     = TRAP_VEC;
      case (bus.redirect_kind)
         2'b00:   target = {base_plus4[XLEN-1:28], bus.redirect_index, 2'b00};
         2'b01:   target = bus.redirect_reg;
         2'b10:   target = base_plus4 + branch_off;
         default: target = TRAP_VEC;
      endcase
   end

   // A redirect masks the head so decode can never consume an entry being flushed.
   assign head_valid = (count != '0) && !bus.redirect_valid;
   assign pop        = head_valid && bus.id_ready;
   assign push       = !bus.redirect_valid && ((count != FULL_CNT) || pop);

   assign bus.imem_addr      = pc;
   assign bus.id_valid       = head_valid;
   assign bus.id_instr       = instr_q[head];
   assign bus.id_pc          = pc_q[head];
   assign bus.iq_count       = count;
   assign bus.misalign_pulse = misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         misalign <= 1'b0;
      end else if (bus.redirect_valid) begin
         pc       <= {target[XLEN-1:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         misalign <= |target[1:0];
      end else begin
         misalign <= 1'b0;
         if (push) begin
            pc   <= pc + XLEN'(4);
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is cleared on reset so the head reads as zero before the first fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (push) begin
         instr_q[tail] <= bus.imem_rdata;
         pc_q[tail]    <= pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (push && (fetch_cnt != '1)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (bus.redirect_valid && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_fetch_stage.sv
// Directed vector bench for pipelined_fetch_stage; a second instance with
// RESET_PC at the top of the address space covers PC wraparound.
module tb_pipelined_fetch_stage;

   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        rv;
      logic [1:0]  kind;
      logic [31:0] base;
      logic [25:0] idx;
      logic [31:0] rreg;
      logic [15:0] imm;
      logic [31:0] e_addr;
      logic [2:0]  e_cnt;
      logic        e_vld;
      logic [31:0] e_pc;
      logic        e_mis;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs [24];

   pipelined_fetch_stage_if #(.XLEN(32), .IQ_DEPTH(4)) bus ();
   pipelined_fetch_stage_if #(.XLEN(32), .IQ_DEPTH(4)) wrap_bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [15:0] flush_cnt;
   logic [31:0] wrap_fetch_cnt;
   logic [15:0] wrap_flush_cnt;
`endif

   pipelined_fetch_stage #(
      .XLEN(32), .IQ_DEPTH(4), .RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0080)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt(fetch_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   pipelined_fetch_stage #(
      .XLEN(32), .IQ_DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0080)
   ) wrap_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(wrap_bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt(wrap_fetch_cnt),
      .flush_cnt(wrap_flush_cnt)
`endif
   );

   assign bus.imem_rdata      = bus.imem_addr ^ MAGIC;
   assign wrap_bus.imem_rdata = wrap_bus.imem_addr ^ MAGIC;

   assign wrap_bus.redirect_valid = 1'b0;
   assign wrap_bus.redirect_kind  = 2'b00;
   assign wrap_bus.redirect_base  = '0;
   assign wrap_bus.redirect_index = '0;
   assign wrap_bus.redirect_reg   = '0;
   assign wrap_bus.redirect_imm   = '0;
   assign wrap_bus.id_ready       = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic r, logic rdy, logic rv, logic [1:0] kind,
                               logic [31:0] base, logic [25:0] idx, logic [31:0] rreg,
                               logic [15:0] imm, logic [31:0] e_addr, logic [2:0] e_cnt,
                               logic e_vld, logic [31:0] e_pc, logic e_mis);
      vec_t v;
      v.rst_n = r;      v.rdy = rdy;     v.rv = rv;       v.kind = kind;
      v.base = base;    v.idx = idx;     v.rreg = rreg;   v.imm = imm;
      v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_pc = e_pc;
      v.e_mis = e_mis;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n              = v.rst_n;
      bus.id_ready       = v.rdy;
      bus.redirect_valid = v.rv;
      bus.redirect_kind  = v.kind;
      bus.redirect_base  = v.base;
      bus.redirect_index = v.idx;
      bus.redirect_reg   = v.rreg;
      bus.redirect_imm   = v.imm;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      applyStimulus(mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Sequential fetch with decode always ready, then a reset mid-stream.
      vecs[0]  = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h004, 1, 1, 32'h000, 0);
      vecs[1]  = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h008, 1, 1, 32'h004, 0);
      vecs[2]  = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h00C, 1, 1, 32'h008, 0);
      vecs[3]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h000, 0, 0, 32'h000, 0);
      // Fill to full with decode stalled, hold, then resume.
      vecs[4]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h000, 0, 0, 32'h000, 0);
      vecs[5]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h004, 1, 1, 32'h000, 0);
      vecs[6]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h008, 2, 1, 32'h000, 0);
      vecs[7]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h00C, 3, 1, 32'h000, 0);
      vecs[8]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h010, 4, 1, 32'h000, 0);
      vecs[9]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h010, 4, 1, 32'h000, 0);
      vecs[10] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h010, 4, 1, 32'h000, 0);
      vecs[11] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h014, 4, 1, 32'h004, 0);
      // Backward branch from a full queue.
      vecs[12] = mk(1, 0, 1, 2'b10, 32'h100, 0, 0, 16'hFFFE, 32'h018, 4, 0, 32'h0, 0);
      vecs[13] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0FC, 0, 0, 32'h000, 0);
      vecs[14] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h100, 1, 1, 32'h0FC, 0);
      // Jump, then back-to-back misaligned register jump.
      vecs[15] = mk(1, 1, 1, 2'b00, 32'h3000_0004, 26'h40, 0, 0, 32'h104, 1, 0, 32'h0, 0);
      vecs[16] = mk(1, 1, 1, 2'b01, 0, 0, 32'h203, 0, 32'h3000_0100, 0, 0, 32'h0, 0);
      vecs[17] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h200, 0, 0, 32'h000, 1);
      vecs[18] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h204, 1, 1, 32'h200, 0);
      // Trap, misaligned register jump, forward branch in consecutive cycles.
      vecs[19] = mk(1, 1, 1, 2'b11, 0, 0, 0, 0, 32'h208, 1, 0, 32'h000, 0);
      vecs[20] = mk(1, 0, 1, 2'b01, 0, 0, 32'h402, 0, 32'h080, 0, 0, 32'h000, 0);
      vecs[21] = mk(1, 0, 1, 2'b10, 32'h400, 0, 0, 16'h0003, 32'h400, 0, 0, 32'h0, 1);
      vecs[22] = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h410, 0, 0, 32'h000, 0);
      vecs[23] = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h414, 1, 1, 32'h410, 0);

      #12;
      checkOutput("reset addr",     bus.imem_addr, 32'h0);
      checkOutput("reset count",    32'(bus.iq_count), 32'h0);
      checkOutput("reset valid",    32'(bus.id_valid), 32'h0);
      checkOutput("reset instr",    bus.id_instr, 32'h0);
      checkOutput("reset pc",       bus.id_pc, 32'h0);
      checkOutput("reset misalign", 32'(bus.misalign_pulse), 32'h0);
      checkOutput("wrap reset addr", wrap_bus.imem_addr, 32'hFFFF_FFFC);

      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         applyStimulus(vecs[k]);
         #1;
         checkOutput($sformatf("v%0d addr", k),     bus.imem_addr, vecs[k].e_addr);
         checkOutput($sformatf("v%0d count", k),    32'(bus.iq_count), 32'(vecs[k].e_cnt));
         checkOutput($sformatf("v%0d valid", k),    32'(bus.id_valid), 32'(vecs[k].e_vld));
         checkOutput($sformatf("v%0d misalign", k), 32'(bus.misalign_pulse), 32'(vecs[k].e_mis));
         if (vecs[k].e_vld) begin
            checkOutput($sformatf("v%0d id_pc", k),    bus.id_pc, vecs[k].e_pc);
            checkOutput($sformatf("v%0d id_instr", k), bus.id_instr, vecs[k].e_pc ^ MAGIC);
         end
         if (k == 0) begin
            checkOutput("wrap first pc",   wrap_bus.id_pc, 32'hFFFF_FFFC);
            checkOutput("wrap first addr", wrap_bus.imem_addr, 32'h0);
         end
         if (k == 1) begin
            checkOutput("wrap second pc",   wrap_bus.id_pc, 32'h0);
            checkOutput("wrap second addr", wrap_bus.imem_addr, 32'h4);
         end
      end

      // Ten pushes and two flushes after a fresh reset, decode stalled.
      @(negedge clk);
      applyStimulus(mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      bus.redirect_valid = 1'b1;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      repeat (5) @(negedge clk);
      bus.redirect_valid = 1'b1;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("perf seq count", 32'(bus.iq_count), 32'd2);
      checkOutput("perf seq addr",  bus.imem_addr, 32'h0000_0088);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("fetch_cnt", fetch_cnt, 32'd10);
      checkOutput("flush_cnt", 32'(flush_cnt), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_fetch_stage.md
PIPELINED_FETCH_STAGE -- requirements
Module: pipelined_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width (>=32).
REQ-002 SHALL have parameter IQ_DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have parameter TRAP_VEC, default 32'h0000_0080, trap redirect target.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 imem_addr  out  XLEN  fetch address, equals PC register, combinational read.
REQ-008 imem_rdata  in  32  instruction word at imem_addr, same cycle.
REQ-009 redirect_valid  in  1  redirect request, one-cycle pulse.
REQ-010 redirect_kind  in  2  00 jump, 01 register, 10 branch, 11 trap.
REQ-011 redirect_base  in  XLEN  PC of redirecting instruction.
REQ-012 redirect_index  in  26  jump index field.
REQ-013 redirect_reg  in  XLEN  register-jump target.
REQ-014 redirect_imm  in  16  branch offset field.
REQ-015 id_valid  out  1  queue head valid; id_ready  in  1  decode accepts head.
REQ-016 id_instr  out  32 and id_pc  out  XLEN  head instruction and its PC.
REQ-017 iq_count  out  log2(IQ_DEPTH)+1  occupied entries.
REQ-018 misalign_pulse  out  1  one-cycle flag: redirect target had nonzero bits [1:0].

Function
REQ-019 Fetch: when redirect_valid=0 and (iq_count<IQ_DEPTH or pop this cycle), SHALL push {imem_addr, imem_rdata} at the tail and set PC<=PC+4 (mod 2^XLEN, wraps to 0).
REQ-020 Full, no pop: SHALL hold PC and queue contents; no push.
REQ-021 Pop: id_valid&&id_ready SHALL remove the head at the edge; simultaneous push+pop keeps iq_count unchanged, including at full.
REQ-022 Empty: id_valid=0; id_instr/id_pc SHALL hold last values (don't-care).
REQ-023 Latency: instruction at PC SHALL appear at id_* one cycle after PC is presented when queue empty.
REQ-024 Target: kind 00 {(base+4)[XLEN-1:28], index, 2'b00}; 01 redirect_reg; 10 base+4+(sign_ext(imm)<<2); 11 TRAP_VEC.
REQ-025 Redirect: SHALL clear queue (iq_count<=0), load PC<=target with bits[1:0] forced 0, no push that cycle.
REQ-026 While redirect_valid=1, id_valid SHALL be forced 0, so no pop completes; redirect has priority over push and pop.
REQ-027 misalign_pulse SHALL assert for the cycle after a redirect whose computed target[1:0]!=0.
REQ-028 Back-to-back redirects: last one wins; each flushes.
REQ-029 Queue SHALL be circular with head/tail pointers wrapping modulo IQ_DEPTH.

Reset
REQ-030 rst_n=0 SHALL immediately set PC=RESET_PC, head=tail=0, iq_count=0, id_valid=0, misalign_pulse=0, id_instr=0, id_pc=0.
REQ-031 Reset mid-operation SHALL discard all queued entries and pending redirect; first fetch after deassertion from RESET_PC.
REQ-032 Deassertion SHALL be honoured on the next rising clk edge; first push occurs on that edge.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN: when defined, SHALL add outputs fetch_cnt (32, pushes) and flush_cnt (16, redirects), reset to 0, saturating at all-ones.
REQ-034 Without FETCH_PERF_CNT_EN, ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset release, id_ready=1, imem returns addr-based word -> id_pc 0,4,8,... one per cycle, first id_valid one cycle after release.
REQ-036 id_ready=0 with IQ_DEPTH=4 -> iq_count 1,2,3,4 then holds; PC stays 0x10; id_ready=1 resumes with id_pc=0.
REQ-037 redirect kind 10, base=0x100, imm=0xFFFE -> next imem_addr 0x0FC, iq_count 0, no id_valid during pulse cycle.
REQ-038 redirect kind 00, base=0x3000_0004, index=0x40 -> imem_addr 0x3000_0100; kind 01 reg=0x203 -> imem_addr 0x200, misalign_pulse=1.
REQ-039 RESET_PC=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; rst_n low mid-fill -> iq_count 0 same cycle.
REQ-040 With FETCH_PERF_CNT_EN: 10 pushes, 2 redirects -> fetch_cnt=10, flush_cnt=2.
